cook_sequencer: RTL and testbench
=================================

Name: cook_sequencer

Overview:
- Cooking-cycle controller for the microwave `main` datapath.
- Takes rising edges from the 12-key pad, the config button, the 4 recipe buttons and the door switch.
- Sequences time entry, countdown, pause/cancel and the done alarm; stores up to N_RECIPES programmed times.
- Drives BCD time digits (7-seg decode is downstream) plus the luz/motor/aquec/som actuators.

Parameters:
- CLK_HZ, 1000, clk cycles per 1 s countdown tick (>=2).
- DONE_S, 3, seconds som stays high in DONE.
- N_RECIPES, 4, recipe slots; width of r.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- t  in  12  keypad levels: [9:0] digits 0-9, [10] start, [11] cancel
- conf  in  1  config button (level)
- r  in  N_RECIPES  recipe buttons (level)
- porta  in  1  door, 1 = open
- dig0  out  4  BCD seconds units
- dig1  out  4  BCD seconds tens
- dig2  out  4  BCD minutes units
- dig3  out  4  BCD minutes tens
- luz  out  1  cavity lamp
- motor  out  1  turntable
- aquec  out  1  magnetron/heater
- som  out  1  buzzer
- busy  out  1  1 in COOK or PAUSE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset state:
  - State IDLE; all digits 0; entry pointer 0; recipe store cleared to 00:00; prescaler and done counter 0.
  - luz = motor = aquec = som = busy = 0.
  - Reset mid-cook aborts immediately, no alarm.
- Key edges: every key/button input is registered once; an event is a rising edge (prev=0, now=1), acted on the following cycle.
  - Same-cycle priority: cancel > start > conf > recipe (lowest index) > digit (lowest index).
  - Held levels generate no repeat.
- Digit entry (IDLE, PROG): each digit edge writes dig[ptr] and increments ptr.
  - Fill order is dig0, dig1, dig2, dig3, so keys 5,2,1 give 01:25.
  - Entering the first digit clears the other digits.
  - A 5th digit is ignored.
  - dig1 may hold 6-9; the value is cooked as written, e.g. 14:76 = 14 min 76 s.
- States:
  - IDLE:
    - digit -> entry.
    - start with time != 0 and porta = 0 -> COOK; prescaler cleared; ptr = 0.
    - start with porta = 1 or time = 0 -> ignored.
    - cancel -> digits and ptr cleared.
    - conf -> ARM.
    - r[k] -> digits loaded from slot k; ptr = 0.
  - ARM (await slot):
    - r[k] -> PROG(k), digits cleared.
    - cancel -> IDLE.
    - digit -> IDLE with the digit discarded (time-of-day setting is outside this block).
  - PROG(k):
    - digits are entered as in IDLE.
    - After the 4th digit, or on start, slot k <= digits -> IDLE with digits kept.
    - cancel -> IDLE with slot k unchanged.
  - COOK:
    - aquec = motor = luz = busy = 1.
    - Prescaler reaching CLK_HZ-1 produces a tick; tick decrements the time.
    - cancel or porta = 1 -> PAUSE, time held.
    - Reaching 00:00 -> DONE in the same cycle as the decrement.
  - PAUSE:
    - aquec = motor = 0; busy = 1.
    - start with porta = 0 -> COOK with the prescaler cleared.
    - cancel -> IDLE with digits cleared.
  - DONE:
    - som = 1, luz = 1, digits show 00:00.
    - After DONE_S ticks, or on cancel or porta rising, -> IDLE.
- Decrement rule:
  - If seconds != 00: BCD seconds - 1 (dig0 0 -> 9 with dig1 - 1).
  - Else if minutes != 00: minutes BCD - 1 and seconds = 59.
  - Example: 01:00 -> 00:59; 10:00 -> 09:59.
- luz is additionally 1 whenever porta = 1, in any state.
- Outputs are registered; state change and digits update 1 cycle after the registered edge.

Optional Feature:
- Macro QUICK_START_EN.
- Defined:
  - start in IDLE with time 00:00 and porta = 0 loads 00:30 and enters COOK.
  - start in COOK adds 30 s: seconds+30 with BCD carry, seconds >= 60 wraps with minutes+1, saturating at 99:59.
- Undefined: both cases ignored, as in Behaviour.

Test Plan (CLK_HZ = 4, DONE_S = 3):
- Entry and cook: keys 5,2,1, start -> digits 01:25, aquec = 1; after 85 ticks DONE with som = 1 for 3 ticks, then IDLE and all outputs 0.
- Wrap: enter 1,0,0,1 (=10:01), start -> after 2 ticks shows 09:59; 14:76 counts 14:76 -> 14:75.
- Pause path: cook 05:00, cancel after 10 ticks -> PAUSE at 04:50, aquec = 0, busy = 1; start -> resumes; cancel twice -> IDLE, 00:00.
- Door: porta = 1 during COOK -> PAUSE, luz = 1; start while porta = 1 ignored; porta = 0 then start -> COOK.
- Recipe: conf, r[2], keys 9,4,3,0 -> slot 2 = 03:49; cancel; r[2] -> digits 03:49; start -> COOK.
- Reset: rst_n = 0 for 1 cycle mid-COOK -> next cycle IDLE, all outputs 0, slot 2 cleared (r[2] loads 00:00).

Source files
------------

// File: rtl/cook_sequencer.sv
// cook_sequencer -- cooking-cycle controller for the microwave datapath.
//
// Purpose: turns keypad, config, recipe and door edges into time entry,
// countdown, pause/cancel, the done alarm and programmed-recipe storage.
// The displayed time is held as four BCD digits {dig3,dig2,dig1,dig0} =
// MM:SS; 7-segment decoding happens downstream.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   t      in   keypad levels: [9:0] digits, [10] start, [11] cancel
//   conf   in   config button level
//   r      in   recipe button levels, one per slot
//   porta  in   door switch, 1 = open
//   dig0..dig3  out  BCD seconds units/tens, minutes units/tens
//   luz, motor, aquec, som  out  lamp, turntable, heater, buzzer
//   busy   out  high while cooking or paused
//
// Optional feature: define QUICK_START_EN to enable quick start (start with
// 00:00 in IDLE cooks 00:30; start while cooking adds 30 s, saturating at
// 99:59). Without the macro both start cases are ignored.

module cook_sequencer #(
  parameter int CLK_HZ    = 1000,
  parameter int DONE_S    = 3,
  parameter int N_RECIPES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [11:0]          t,
  input  logic                 conf,
  input  logic [N_RECIPES-1:0] r,
  input  logic                 porta,
  output logic [3:0]           dig0,
  output logic [3:0]           dig1,
  output logic [3:0]           dig2,
  output logic [3:0]           dig3,
  output logic                 luz,
  output logic                 motor,
  output logic                 aquec,
  output logic                 som,
  output logic                 busy
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int DW = $clog2(DONE_S + 1);
  localparam int RW = (N_RECIPES > 1) ? $clog2(N_RECIPES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DONE_MAX  = DW'(DONE_S - 1);
`ifdef QUICK_START_EN
  localparam bit QS_EN = 1'b1;
`else
  localparam bit QS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_PROG  = 3'd2,
    S_COOK  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Write one entered digit at the entry pointer; the first digit clears the rest.
  function automatic logic [15:0] put_digit(input logic [15:0] v, input logic [2:0] p,
                                            input logic [3:0] d);
    logic [15:0] o;
    o = v;
    case (p)
      3'd0:    o = {12'h000, d};
      3'd1:    o[7:4] = d;
      3'd2:    o[11:8] = d;
      3'd3:    o[15:12] = d;
      default: o = v;
    endcase
    return o;
  endfunction

  // One-second BCD decrement of MM:SS; seconds tens may legally exceed 5.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] o;
    o = v;
    if (v[7:0] != 8'h00) begin
      if (v[3:0] != 4'd0) begin
        o[3:0] = v[3:0] - 4'd1;
      end else begin
        o[3:0] = 4'd9;
        o[7:4] = v[7:4] - 4'd1;
      end
    end else if (v[15:8] != 8'h00) begin
      o[7:0] = 8'h59;
      if (v[11:8] != 4'd0) begin
        o[11:8] = v[11:8] - 4'd1;
      end else begin
        o[11:8]  = 4'd9;
        o[15:12] = v[15:12] - 4'd1;
      end
    end else begin
      o = v;
    end
    return o;
  endfunction

  // Add 30 s with carry into minutes, saturating at 99:59.
  function automatic logic [15:0] add30(input logic [15:0] v);
    logic [15:0] o;
    logic [3:0]  s10;
    o   = v;
    s10 = v[7:4] + 4'd3;
    if (s10 >= 4'd6) begin
      if (v[15:8] == 8'h99) begin
        o = 16'h9959;
      end else begin
        o[7:4] = s10 - 4'd6;
        if (v[11:8] == 4'd9) begin
          o[11:8]  = 4'd0;
          o[15:12] = v[15:12] + 4'd1;
        end else begin
          o[11:8] = v[11:8] + 4'd1;
        end
      end
    end else begin
      o[7:4] = s10;
    end
    return o;
  endfunction

  state_e                 state_q, state_d;
  logic [15:0]            tm_q, tm_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [DW-1:0]          done_q, done_d;
  logic [RW-1:0]          slot_q, slot_d;
  logic [15:0]            rec_q [N_RECIPES];
  logic                   rec_we;
  logic [15:0]            rec_wdata;
  logic [11:0]            t_q, t_prev_q;
  logic                   conf_q, conf_prev_q, porta_q, porta_prev_q;
  logic [N_RECIPES-1:0]   r_q, r_prev_q;
  logic                   luz_q, motor_q, aquec_q, som_q, busy_q;
  logic                   luz_d, motor_d, aquec_d, som_d, busy_d;

  logic [11:0]            t_ev;
  logic [N_RECIPES-1:0]   r_ev;
  logic                   ev_cancel, ev_start, ev_conf, ev_rec, ev_dig, porta_rise, tick;
  logic [3:0]             dig_val;
  logic [RW-1:0]          rec_idx;

  // Register every button once and keep the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q          <= 12'h000;
      t_prev_q     <= 12'h000;
      conf_q       <= 1'b0;
      conf_prev_q  <= 1'b0;
      r_q          <= {N_RECIPES{1'b0}};
      r_prev_q     <= {N_RECIPES{1'b0}};
      porta_q      <= 1'b0;
      porta_prev_q <= 1'b0;
    end else begin
      t_q          <= t;
      t_prev_q     <= t_q;
      conf_q       <= conf;
      conf_prev_q  <= conf_q;
      r_q          <= r;
      r_prev_q     <= r_q;
      porta_q      <= porta;
      porta_prev_q <= porta_q;
    end
  end

  // Rising-edge events, resolved so only the highest-priority one is seen.
  always_comb begin
    t_ev       = t_q & ~t_prev_q;
    r_ev       = r_q & ~r_prev_q;
    porta_rise = porta_q & ~porta_prev_q;
    ev_cancel  = t_ev[11];
    ev_start   = t_ev[10] & ~ev_cancel;
    ev_conf    = conf_q & ~conf_prev_q & ~ev_cancel & ~ev_start;
    ev_rec     = (|r_ev) & ~ev_cancel & ~ev_start & ~ev_conf;
    ev_dig     = (|t_ev[9:0]) & ~ev_cancel & ~ev_start & ~ev_conf & ~(|r_ev);
    dig_val    = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (t_ev[i]) dig_val = 4'(i);
    end
    rec_idx = {RW{1'b0}};
    for (int i = N_RECIPES - 1; i >= 0; i--) begin
      if (r_ev[i]) rec_idx = RW'(i);
    end
  end

  // State register: FSM state, time digits, counters, recipe store and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tm_q    <= 16'h0000;
      ptr_q   <= 3'd0;
      presc_q <= {PW{1'b0}};
      done_q  <= {DW{1'b0}};
      slot_q  <= {RW{1'b0}};
      for (int i = 0; i < N_RECIPES; i++) rec_q[i] <= 16'h0000;
      luz_q   <= 1'b0;
      motor_q <= 1'b0;
      aquec_q <= 1'b0;
      som_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tm_q    <= tm_d;
      ptr_q   <= ptr_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      slot_q  <= slot_d;
      if (rec_we) rec_q[slot_q] <= rec_wdata;
      luz_q   <= luz_d;
      motor_q <= motor_d;
      aquec_q <= aquec_d;
      som_q   <= som_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_d   = state_q;
    tm_d      = tm_q;
    ptr_d     = ptr_q;
    presc_d   = presc_q;
    done_d    = done_q;
    slot_d    = slot_q;
    rec_we    = 1'b0;
    rec_wdata = tm_q;
    tick      = (presc_q == PRESC_MAX);
    case (state_q)
      S_IDLE: begin
        presc_d = {PW{1'b0}};
        if (ev_cancel) begin
          tm_d  = 16'h0000;
          ptr_d = 3'd0;
        end else if (ev_start) begin
          if (tm_q != 16'h0000 && !porta_q) begin
            state_d = S_COOK;
            ptr_d   = 3'd0;
          end else if (QS_EN && tm_q == 16'h0000 && !porta_q) begin
            state_d = S_COOK;
            tm_d    = 16'h0030;
            ptr_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (ev_conf) begin
          state_d = S_ARM;
        end else if (ev_rec) begin
          tm_d  = rec_q[rec_idx];
          ptr_d = 3'd0;
        end else if (ev_dig && ptr_q < 3'd4) begin
          tm_d  = put_digit(tm_q, ptr_q, dig_val);
          ptr_d = ptr_q + 3'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        if (ev_cancel) begin
          state_d = S_IDLE;
        end else if (ev_rec) begin
          state_d = S_PROG;
          slot_d  = rec_idx;
          tm_d    = 16'h0000;
          ptr_d   = 3'd0;
        end else if (ev_dig) begin
          // Time-of-day entry is handled elsewhere; the digit is dropped.
          state_d = S_IDLE;
        end else begin
          state_d = S_ARM;
        end
      end
      S_PROG: begin
        if (ev_cancel) begin
          state_d = S_IDLE;
          tm_d    = 16'h0000;
          ptr_d   = 3'd0;
        end else if (ev_start) begin
          rec_we  = 1'b1;
          state_d = S_IDLE;
          ptr_d   = 3'd0;
        end else if (ev_dig && ptr_q < 3'd4) begin
          tm_d  = put_digit(tm_q, ptr_q, dig_val);
          ptr_d = ptr_q + 3'd1;
          if (ptr_q == 3'd3) begin
            // Fourth digit completes the recipe: store what is now displayed.
            rec_we    = 1'b1;
            rec_wdata = tm_d;
            state_d   = S_IDLE;
            ptr_d     = 3'd0;
          end else begin
            state_d = S_PROG;
          end
        end else begin
          state_d = S_PROG;
        end
      end
      S_COOK: begin
        if (ev_cancel || porta_q) begin
          state_d = S_PAUSE;
        end else begin
          presc_d = tick ? {PW{1'b0}} : presc_q + PW'(1);
          if (QS_EN && ev_start) begin
            tm_d = add30(tm_q);
          end else if (tick) begin
            tm_d = bcd_dec(tm_q);
            if (tm_d == 16'h0000) begin
              state_d = S_DONE;
              done_d  = {DW{1'b0}};
            end else begin
              state_d = S_COOK;
            end
          end else begin
            state_d = S_COOK;
          end
        end
      end
      S_PAUSE: begin
        if (ev_cancel) begin
          state_d = S_IDLE;
          tm_d    = 16'h0000;
          ptr_d   = 3'd0;
        end else if (ev_start && !porta_q) begin
          state_d = S_COOK;
          presc_d = {PW{1'b0}};
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_DONE: begin
        tm_d    = 16'h0000;
        presc_d = tick ? {PW{1'b0}} : presc_q + PW'(1);
        if (ev_cancel || porta_rise) begin
          state_d = S_IDLE;
          ptr_d   = 3'd0;
        end else if (tick) begin
          if (done_q == DONE_MAX) begin
            state_d = S_IDLE;
            ptr_d   = 3'd0;
          end else begin
            done_d = done_q + DW'(1);
          end
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tm_d    = 16'h0000;
        ptr_d   = 3'd0;
      end
    endcase
  end

  // Actuator levels for the upcoming state; registered alongside it.
  always_comb begin
    motor_d = (state_d == S_COOK);
    aquec_d = (state_d == S_COOK);
    som_d   = (state_d == S_DONE);
    busy_d  = (state_d == S_COOK) || (state_d == S_PAUSE);
    luz_d   = porta_q || (state_d == S_COOK) || (state_d == S_DONE);
  end

  assign dig0  = tm_q[3:0];
  assign dig1  = tm_q[7:4];
  assign dig2  = tm_q[11:8];
  assign dig3  = tm_q[15:12];
  assign luz   = luz_q;
  assign motor = motor_q;
  assign aquec = aquec_q;
  assign som   = som_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_cook_sequencer.sv
module tb_cook_sequencer;

  logic        clk;
  logic        rst_n;
  logic [11:0] t;
  logic        conf;
  logic [3:0]  r;
  logic        porta;
  logic [3:0]  dig0, dig1, dig2, dig3;
  logic        luz, motor, aquec, som, busy;

  int n_cmp;
  int n_bad;

  wire [15:0] tm   = {dig3, dig2, dig1, dig0};
  // {luz, motor, aquec, som, busy}
  wire [4:0]  outs = {luz, motor, aquec, som, busy};

  localparam logic [4:0] O_OFF   = 5'b00000;
  localparam logic [4:0] O_COOK  = 5'b11101;
  localparam logic [4:0] O_PAUSE = 5'b00001;
  localparam logic [4:0] O_DONE  = 5'b10010;
  localparam logic [4:0] O_DOOR  = 5'b10001;

  cook_sequencer #(.CLK_HZ(4), .DONE_S(3), .N_RECIPES(4)) dut (
    .clk(clk), .rst_n(rst_n), .t(t), .conf(conf), .r(r), .porta(porta),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .luz(luz), .motor(motor), .aquec(aquec), .som(som), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle pulse; returns on the negedge after the DUT has acted on it.
  task automatic press(input logic [11:0] tv, input logic cf, input logic [3:0] rv);
    t = tv; conf = cf; r = rv;
    @(negedge clk);
    t = 12'h000; conf = 1'b0; r = 4'b0000;
    @(negedge clk);
  endtask

  task automatic key(input int k);
    logic [11:0] v;
    v = 12'h000;
    v[k] = 1'b1;
    press(v, 1'b0, 4'b0000);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; t = 12'h000; conf = 1'b0; r = 4'b0000; porta = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    n_cmp++; if (tm !== 16'h0000) begin n_bad++; $display("FAIL reset_time: got %h expected %h", tm, 16'h0000); end
    n_cmp++; if (outs !== O_OFF) begin n_bad++; $display("FAIL reset_outs: got %b expected %b", outs, O_OFF); end
  endtask

  task automatic test_entry_cook;
    key(5); key(2); key(1);
    n_cmp++; if (tm !== 16'h0125) begin n_bad++; $display("FAIL entry_time: got %h expected %h", tm, 16'h0125); end
    key(10);
    n_cmp++; if (outs !== O_COOK) begin n_bad++; $display("FAIL cook_outs: got %b expected %b", outs, O_COOK); end
    cyc(339);
    n_cmp++; if (tm !== 16'h0001) begin n_bad++; $display("FAIL cook_last_sec: got %h expected %h", tm, 16'h0001); end
    cyc(1);
    n_cmp++; if (outs !== O_DONE) begin n_bad++; $display("FAIL done_outs: got %b expected %b", outs, O_DONE); end
    n_cmp++; if (tm !== 16'h0000) begin n_bad++; $display("FAIL done_time: got %h expected %h", tm, 16'h0000); end
    cyc(11);
    n_cmp++; if (outs !== O_DONE) begin n_bad++; $display("FAIL done_hold: got %b expected %b", outs, O_DONE); end
    cyc(1);
    n_cmp++; if (outs !== O_OFF) begin n_bad++; $display("FAIL done_exit: got %b expected %b", outs, O_OFF); end
  endtask

  task automatic test_wrap;
    key(1); key(0); key(0); key(1);
    n_cmp++; if (tm !== 16'h1001) begin n_bad++; $display("FAIL wrap_entry: got %h expected %h", tm, 16'h1001); end
    key(10);
    cyc(4);
    n_cmp++; if (tm !== 16'h1000) begin n_bad++; $display("FAIL wrap_tick1: got %h expected %h", tm, 16'h1000); end
    cyc(4);
    n_cmp++; if (tm !== 16'h0959) begin n_bad++; $display("FAIL wrap_tick2: got %h expected %h", tm, 16'h0959); end
    key(11); key(11);
    key(6); key(7); key(4); key(1);
    key(10);
    cyc(4);
    n_cmp++; if (tm !== 16'h1475) begin n_bad++; $display("FAIL wrap_1476: got %h expected %h", tm, 16'h1475); end
    key(11); key(11);
  endtask

  task automatic test_pause;
    key(0); key(0); key(5);
    key(10);
    cyc(40);
    key(11);
    n_cmp++; if (tm !== 16'h0450) begin n_bad++; $display("FAIL pause_time: got %h expected %h", tm, 16'h0450); end
    n_cmp++; if (outs !== O_PAUSE) begin n_bad++; $display("FAIL pause_outs: got %b expected %b", outs, O_PAUSE); end
    cyc(8);
    n_cmp++; if (tm !== 16'h0450) begin n_bad++; $display("FAIL pause_hold: got %h expected %h", tm, 16'h0450); end
    key(10);
    n_cmp++; if (outs !== O_COOK) begin n_bad++; $display("FAIL resume_outs: got %b expected %b", outs, O_COOK); end
    cyc(4);
    n_cmp++; if (tm !== 16'h0449) begin n_bad++; $display("FAIL resume_tick: got %h expected %h", tm, 16'h0449); end
    key(11); key(11);
    n_cmp++; if (tm !== 16'h0000) begin n_bad++; $display("FAIL cancel2_time: got %h expected %h", tm, 16'h0000); end
    n_cmp++; if (outs !== O_OFF) begin n_bad++; $display("FAIL cancel2_outs: got %b expected %b", outs, O_OFF); end
  endtask

  task automatic test_door;
    key(0); key(3);
    key(10);
    cyc(4);
    n_cmp++; if (tm !== 16'h0029) begin n_bad++; $display("FAIL door_cook: got %h expected %h", tm, 16'h0029); end
    porta = 1'b1;
    cyc(2);
    n_cmp++; if (outs !== O_DOOR) begin n_bad++; $display("FAIL door_open: got %b expected %b", outs, O_DOOR); end
    key(10);
    n_cmp++; if (outs !== O_DOOR) begin n_bad++; $display("FAIL door_start_ignored: got %b expected %b", outs, O_DOOR); end
    porta = 1'b0;
    cyc(2);
    n_cmp++; if (outs !== O_PAUSE) begin n_bad++; $display("FAIL door_closed: got %b expected %b", outs, O_PAUSE); end
    key(10);
    n_cmp++; if (outs !== O_COOK) begin n_bad++; $display("FAIL door_resume: got %b expected %b", outs, O_COOK); end
    n_cmp++; if (tm !== 16'h0029) begin n_bad++; $display("FAIL door_resume_time: got %h expected %h", tm, 16'h0029); end
    key(11); key(11);
  endtask

  task automatic test_entry_edges;
    t = 12'h080;
    cyc(5);
    t = 12'h000;
    cyc(1);
    key(8);
    n_cmp++; if (tm !== 16'h0087) begin n_bad++; $display("FAIL held_no_repeat: got %h expected %h", tm, 16'h0087); end
    key(11);
    key(1); key(2); key(3); key(4); key(5);
    n_cmp++; if (tm !== 16'h4321) begin n_bad++; $display("FAIL fifth_digit: got %h expected %h", tm, 16'h4321); end
    press(12'h808, 1'b0, 4'b0000);
    n_cmp++; if (tm !== 16'h0000) begin n_bad++; $display("FAIL cancel_priority: got %h expected %h", tm, 16'h0000); end
    key(10);
    n_cmp++; if (outs !== O_OFF) begin n_bad++; $display("FAIL start_zero: got %b expected %b", outs, O_OFF); end
  endtask

  task automatic test_recipe;
    press(12'h000, 1'b1, 4'b0000);
    press(12'h000, 1'b0, 4'b0100);
    key(9); key(4); key(3); key(0);
    n_cmp++; if (tm !== 16'h0349) begin n_bad++; $display("FAIL prog_time: got %h expected %h", tm, 16'h0349); end
    key(11);
    n_cmp++; if (tm !== 16'h0000) begin n_bad++; $display("FAIL prog_cancel: got %h expected %h", tm, 16'h0000); end
    press(12'h000, 1'b1, 4'b0000);
    press(12'h000, 1'b0, 4'b0010);
    key(7);
    key(10);
    key(11);
    press(12'h000, 1'b0, 4'b0010);
    n_cmp++; if (tm !== 16'h0007) begin n_bad++; $display("FAIL prog_start_store: got %h expected %h", tm, 16'h0007); end
    press(12'h000, 1'b0, 4'b0100);
    n_cmp++; if (tm !== 16'h0349) begin n_bad++; $display("FAIL recall_slot2: got %h expected %h", tm, 16'h0349); end
    key(10);
    n_cmp++; if (outs !== O_COOK) begin n_bad++; $display("FAIL recipe_cook: got %b expected %b", outs, O_COOK); end
    cyc(6);
    n_cmp++; if (tm !== 16'h0348) begin n_bad++; $display("FAIL recipe_tick: got %h expected %h", tm, 16'h0348); end
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    n_cmp++; if (outs !== O_OFF) begin n_bad++; $display("FAIL midcook_reset_outs: got %b expected %b", outs, O_OFF); end
    n_cmp++; if (tm !== 16'h0000) begin n_bad++; $display("FAIL midcook_reset_time: got %h expected %h", tm, 16'h0000); end
    press(12'h000, 1'b0, 4'b0100);
    n_cmp++; if (tm !== 16'h0000) begin n_bad++; $display("FAIL slot_cleared: got %h expected %h", tm, 16'h0000); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_entry_cook();
    test_wrap();
    test_pause();
    test_door();
    test_entry_edges();
    test_recipe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
